alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational calculator ALU, used by the UART calculator datapath.
- Accepts one signed operation through a valid/ready input handshake.
- Add/sub complete in one cycle; multiply and divide run iteratively over WIDTH cycles.
- Presents result plus remainder, error and overflow flags through a valid/ready output handshake.
- Frees the UART front end from a large combinational multiplier/divider and adds overflow reporting.

Parameters:
- WIDTH, 16, operand/result width in bits, two's complement signed, minimum 4.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept an operation
- opcode  input  2  00 add, 01 sub, 10 mul, 11 div
- op1  input  WIDTH  signed first operand
- op2  input  WIDTH  signed second operand (divisor for div)
- out_valid  output  1  result bundle valid
- out_ready  input  1  consumer accepts result bundle
- result  output  WIDTH  signed result
- remainder  output  WIDTH  signed remainder (div only, else 0)
- error  output  1  divide by zero
- overflow  output  1  signed result not representable in WIDTH bits

Behaviour:
- Reset:
  - Takes effect on the clk edge where rst=1, including mid-operation; any in-flight operation is discarded, no out_valid is produced for it.
  - After reset: state IDLE, in_ready=1, out_valid=0, result=0, remainder=0, error=0, overflow=0, iteration counter=0.
- States:
  - IDLE:
    - in_ready=1. Transfer occurs when in_valid & in_ready; opcode/op1/op2 are latched.
    - add/sub -> DONE.
    - div with op2==0 -> DONE with error=1, result=0, remainder=0, overflow=0.
    - mul/div otherwise -> CALC with counter=WIDTH-1.
  - CALC:
    - in_ready=0. One iteration per cycle on operand magnitudes: shift-add multiply or restoring divide.
    - At counter==0, apply the sign correction, register the outputs and go to DONE; otherwise decrement the counter.
  - DONE:
    - out_valid=1, outputs held stable, in_ready=0.
    - out_valid & out_ready -> IDLE (in_ready=1 next cycle).
    - Outputs are held indefinitely under backpressure.
- Latency, accept on edge N:
  - add/sub and div-by-zero: out_valid high from edge N+1.
  - mul/div: out_valid high from edge N+WIDTH+1.
  - No overlap: the next accept is at the earliest the edge after the output handshake.
- Arithmetic:
  - add/sub: result = low WIDTH bits. overflow=1 when operand signs make the true result fall outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - mul:
    - result = low WIDTH bits of the 2*WIDTH signed product.
    - overflow=1 if the upper WIDTH+1 bits of the product are not all equal.
    - remainder=0.
  - div:
    - Quotient truncates toward zero; remainder takes the sign of op1; op1 = q*op2 + r.
    - Special case MIN/-1: result=MIN, remainder=0, overflow=1.
  - error and overflow are never both 1.
- Protocol:
  - in_valid while in_ready=0 is ignored; the producer must hold its request.
  - out_ready while out_valid=0 is ignored.
  - result/remainder/flags are only meaningful while out_valid=1. They retain their last values after handshake, until the next DONE entry or reset.

Test Plan:
- WIDTH=16, op1=15, op2=5, opcodes 00,01,10,11 in turn with out_ready=1 -> results 20, 10, 75, 3 rem 0. All flags 0. Latencies 1, 1, 17, 17 cycles.
- div: op1=-7, op2=2 -> result=-3, remainder=-1. Then op1=7, op2=-2 -> result=-3, remainder=1. Then op1=-32768, op2=-1 -> result=-32768, overflow=1.
- div by zero: op1=123, op2=0 -> out_valid at N+1, error=1, result=0, overflow=0.
- overflow:
  - add 32767+1 -> result=-32768, overflow=1.
  - sub -32768-1 -> result=32767, overflow=1.
  - mul 300*300 -> result=24464, overflow=1.
  - mul -128*256 -> result=-32768, overflow=0.
- backpressure: mul 15*5 with out_ready=0 for 10 cycles after out_valid -> out_valid and result=75 stable, in_ready=0 throughout, and a second in_valid is not accepted. out_ready=1 -> IDLE next cycle, then the second request is accepted.
- reset mid-CALC: start div 1000/7, assert rst for 1 cycle at iteration 5 -> next cycle all outputs 0, in_ready=1, no out_valid. A new add 2+3 then yields 5 at N+1.

Source files
------------

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operation request / result handshake bundle for alu_seq
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       opcode;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             error;
    logic             overflow;

    modport master (
        output in_valid,
        output opcode,
        output op1,
        output op2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  remainder,
        input  error,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  opcode,
        input  op1,
        input  op2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output remainder,
        output error,
        output overflow
    );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential signed ALU: one-cycle add/sub, WIDTH-cycle shift-add mul and restoring div
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            in_ready;
    logic            out_valid;
    logic            accept;
    logic            last_iter;

    logic [1:0]         op_q;
    logic               neg_q;
    logic               neg1_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;

    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] remo_q;
    logic             err_q;
    logic             ovf_q;

    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic             div_zero;

    logic [WIDTH:0]     mul_add;
    logic [WIDTH:0]     mul_hi;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_trial;
    logic               div_fit;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     prod_top;
    logic               mul_ovf;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               div_ovf;

    // Operand decode at accept time; magnitudes are unsigned so |MIN| fits in WIDTH bits.
    always_comb begin
        s1       = bus.op1[WIDTH-1];
        s2       = bus.op2[WIDTH-1];
        mag1     = s1 ? -bus.op1 : bus.op1;
        mag2     = s2 ? -bus.op2 : bus.op2;
        sum      = bus.op1 + bus.op2;
        diff     = bus.op1 - bus.op2;
        add_ovf  = (s1 == s2) && (sum[WIDTH-1] != s1);
        sub_ovf  = (s1 != s2) && (diff[WIDTH-1] != s1);
        div_zero = (bus.op2 == '0);
    end

    // One iteration of each algorithm; only the one matching op_q is used at the end.
    always_comb begin
        mul_add   = prod_q[0] ? {1'b0, mcand_q} : '0;
        mul_hi    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + mul_add;
        prod_step = {mul_hi, prod_q[WIDTH-1:1]};

        div_sh    = {rem_q, quo_q[WIDTH-1]};
        div_trial = div_sh - {1'b0, mcand_q};
        div_fit   = ~div_trial[WIDTH];
        rem_step  = div_fit ? div_trial[WIDTH-1:0] : div_sh[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], div_fit};
    end

    // Sign correction applied on the final iteration's values.
    always_comb begin
        prod_s   = neg_q ? -prod_step : prod_step;
        prod_top = prod_s[2*WIDTH-1:WIDTH-1];
        mul_ovf  = (prod_top != '0) && (prod_top != '1);
        quo_s    = neg_q ? -quo_step : quo_step;
        rem_s    = neg1_q ? -rem_step : rem_step;
        div_ovf  = ~neg_q & quo_step[WIDTH-1];
    end

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_iter = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if ((bus.opcode == OP_MUL) || ((bus.opcode == OP_DIV) && !div_zero)) begin
                        state_nxt = CALC;
                        cnt_nxt   = CW'(WIDTH - 1);
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            neg_q   <= 1'b0;
            neg1_q  <= 1'b0;
            mcand_q <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
            remo_q  <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= bus.opcode;
                        neg_q   <= s1 ^ s2;
                        neg1_q  <= s1;
                        mcand_q <= (bus.opcode == OP_MUL) ? mag1 : mag2;
                        prod_q  <= {{WIDTH{1'b0}}, mag2};
                        rem_q   <= '0;
                        quo_q   <= mag1;
                        case (bus.opcode)
                            OP_ADD: begin
                                res_q  <= sum;
                                remo_q <= '0;
                                err_q  <= 1'b0;
                                ovf_q  <= add_ovf;
                            end
                            OP_SUB: begin
                                res_q  <= diff;
                                remo_q <= '0;
                                err_q  <= 1'b0;
                                ovf_q  <= sub_ovf;
                            end
                            OP_DIV: begin
                                if (div_zero) begin
                                    res_q  <= '0;
                                    remo_q <= '0;
                                    err_q  <= 1'b1;
                                    ovf_q  <= 1'b0;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                CALC: begin
                    prod_q <= prod_step;
                    rem_q  <= rem_step;
                    quo_q  <= quo_step;
                    if (last_iter) begin
                        err_q <= 1'b0;
                        if (op_q == OP_MUL) begin
                            res_q  <= prod_s[WIDTH-1:0];
                            remo_q <= '0;
                            ovf_q  <= mul_ovf;
                        end else begin
                            res_q  <= quo_s;
                            remo_q <= rem_s;
                            ovf_q  <= div_ovf;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = res_q;
    assign bus.remainder = remo_q;
    assign bus.error     = err_q;
    assign bus.overflow  = ovf_q;

    a_flags_exclusive: assert property (@(posedge clk) disable iff (rst) !(err_q && ovf_q));

    a_hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
        (state == DONE && !bus.out_ready) |=> (state == DONE && $stable(res_q) && $stable(remo_q)));
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized scoreboard bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
    localparam int W    = 16;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] MUL = 2'b10;
    localparam logic [1:0] DIV = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] rem;
        logic         err;
        logic         ovf;
        int           lat;
        int           acc;
    } exp_t;

    exp_t expq[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   ready_rand = 1'b0;
    logic tb_ready;
    logic rnd_ready;

    assign bus.out_ready = ready_rand ? rnd_ready : tb_ready;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_ready = ($urandom_range(0, 3) != 0);

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic check(input string name, input longint act, input longint want);
        n_checks++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, want);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Reference model: plain integer arithmetic on the signed operand values.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a_bits, input logic [W-1:0] b_bits);
        exp_t   e;
        longint a;
        longint b;
        longint t;
        a = sx(a_bits);
        b = sx(b_bits);
        e.rem = '0;
        e.err = 1'b0;
        e.ovf = 1'b0;
        e.lat = 1;
        e.acc = 0;
        t = 0;
        case (op)
            ADD: t = a + b;
            SUB: t = a - b;
            MUL: begin
                t = a * b;
                e.lat = W + 1;
            end
            default: begin
                if (b == 0) begin
                    e.err = 1'b1;
                end else begin
                    t = a / b;
                    e.rem = W'(a % b);
                    e.lat = W + 1;
                end
            end
        endcase
        e.res = W'(t);
        if (!e.err) e.ovf = (t > MAXV) || (t < MINV);
        return e;
    endfunction

    task automatic issue_e(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
        int   waited;
        exp_t ee;
        waited = 0;
        ee = e;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.op1      = a;
        bus.op2      = b;
        while (!bus.in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready) begin
            ee.acc = cyc + 1;
            expq.push_back(ee);
        end else begin
            timeout("accept");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic issue_x(input logic [1:0] op, input int a, input int b, input int res, input int rem,
                           input bit err, input bit ovf, input int lat);
        exp_t e;
        e.res = W'(res);
        e.rem = W'(rem);
        e.err = err;
        e.ovf = ovf;
        e.lat = lat;
        e.acc = 0;
        issue_e(op, W'(a), W'(b), e);
    endtask

    task automatic issue_rand(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue_e(op, a, b, model(op, a, b));
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (!(bus.in_ready && expq.size() == 0) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) timeout("idle");
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return W'(MINV);
            1:       return W'(MAXV);
            2:       return '0;
            3:       return W'(1);
            4:       return '1;
            5:       return W'($urandom_range(0, 511)) - W'(256);
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard monitor: compares once per result, at the first cycle out_valid is seen.
    exp_t mon_e;
    bit   seen = 1'b0;
    always @(negedge clk) begin
        if (!bus.out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (expq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out_valid: result %0d with no request outstanding", sx(bus.result));
            end else begin
                mon_e = expq.pop_front();
                check("result", sx(bus.result), sx(mon_e.res));
                check("remainder", sx(bus.remainder), sx(mon_e.rem));
                check("error", bus.error, mon_e.err);
                check("overflow", bus.overflow, mon_e.ovf);
                check("latency", cyc - mon_e.acc + 1, mon_e.lat);
                check("in_ready_in_done", bus.in_ready, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] rop;
        int         waited;
        rst          = 1'b1;
        tb_ready     = 1'b1;
        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.op1      = '0;
        bus.op2      = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", sx(bus.result), 0);
        check("rst_remainder", sx(bus.remainder), 0);
        check("rst_flags", {bus.error, bus.overflow}, 0);
        rst = 1'b0;
        @(negedge clk);

        //      op    op1     op2    result  rem  err ovf  latency
        issue_x(ADD,     15,     5,      20,   0,  0,  0,  1);
        issue_x(SUB,     15,     5,      10,   0,  0,  0,  1);
        issue_x(MUL,     15,     5,      75,   0,  0,  0,  W + 1);
        issue_x(DIV,     15,     5,       3,   0,  0,  0,  W + 1);
        issue_x(DIV,     -7,     2,      -3,  -1,  0,  0,  W + 1);
        issue_x(DIV,      7,    -2,      -3,   1,  0,  0,  W + 1);
        issue_x(DIV, -32768,    -1,  -32768,   0,  0,  1,  W + 1);
        issue_x(DIV,    123,     0,       0,   0,  1,  0,  1);
        issue_x(ADD,  32767,     1,  -32768,   0,  0,  1,  1);
        issue_x(SUB, -32768,     1,   32767,   0,  0,  1,  1);
        issue_x(MUL,    300,   300,   24464,   0,  0,  1,  W + 1);
        issue_x(MUL,   -128,   256,  -32768,   0,  0,  0,  W + 1);
        issue_x(MUL, -32768,    -1,  -32768,   0,  0,  1,  W + 1);
        issue_x(DIV, -32768,     1,  -32768,   0,  0,  0,  W + 1);
        issue_x(DIV,      5, -32768,      0,   5,  0,  0,  W + 1);
        wait_idle();

        // Backpressure: result held, second request refused until the handshake.
        tb_ready = 1'b0;
        issue_x(MUL, 15, 5, 75, 0, 0, 0, W + 1);
        waited = 0;
        while (!bus.out_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.out_valid) timeout("bp_out_valid");
        bus.in_valid = 1'b1;
        bus.opcode   = ADD;
        bus.op1      = W'(2);
        bus.op2      = W'(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_hold_result", sx(bus.result), 75);
            check("bp_in_ready", bus.in_ready, 0);
        end
        tb_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_out_valid", bus.out_valid, 0);
        issue_x(ADD, 2, 3, 5, 0, 0, 0, 1);
        wait_idle();

        // Reset in the middle of a division discards it.
        issue_x(DIV, 1000, 7, 142, 6, 0, 0, W + 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_result", sx(bus.result), 0);
        check("midrst_remainder", sx(bus.remainder), 0);
        check("midrst_flags", {bus.error, bus.overflow}, 0);
        repeat (W + 4) @(negedge clk);
        check("midrst_no_result", bus.out_valid, 0);
        issue_x(ADD, 2, 3, 5, 0, 0, 0, 1);
        wait_idle();

        ready_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            rop = 2'($urandom_range(0, 3));
            issue_rand(rop, rnd_operand(), rnd_operand());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        ready_rand = 1'b0;
        wait_idle();
        check("queue_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
